// File: rtl/seven_seg_scan_if.sv
// Bus between a datapath and the seven-segment scan driver: display data
// and load strobe flow in, the registered display pins and frame tick flow out.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_tick;

  // Datapath side: supplies values to display, observes the pins.
  modport master (
    output digits, dp_in, digit_en, blank_lz, load,
    input  seg, dp, anode, frame_tick
  );

  // Driver side.
  modport slave (
    input  digits, dp_in, digit_en, blank_lz, load,
    output seg, dp, anode, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver. Display data is
// captured into shadow registers only at frame boundaries so a frame is
// never drawn from a mix of old and new values.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] TC_VAL   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tc;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_blank_lz;
  logic                    pending;

  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   anode_nx;
  logic [6:0]              seg_nx;
  logic                    dp_nx;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F.
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'h0: seg_lut = 7'b1000000;
      4'h1: seg_lut = 7'b1111001;
      4'h2: seg_lut = 7'b0100100;
      4'h3: seg_lut = 7'b0110000;
      4'h4: seg_lut = 7'b0011001;
      4'h5: seg_lut = 7'b0010010;
      4'h6: seg_lut = 7'b0000010;
      4'h7: seg_lut = 7'b1111000;
      4'h8: seg_lut = 7'b0000000;
      4'h9: seg_lut = 7'b0010000;
      4'hA: seg_lut = 7'b0001000;
      4'hB: seg_lut = 7'b0000011;
      4'hC: seg_lut = 7'b1000110;
      4'hD: seg_lut = 7'b0100001;
      4'hE: seg_lut = 7'b0000110;
      default: seg_lut = 7'b0001110;
    endcase
  endfunction

  assign tc       = (cnt == TC_VAL);
  assign boundary = tc && (idx == LAST_IDX);

  // Refresh prescaler: counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n)  cnt <= '0;
    else if (tc) cnt <= '0;
    else         cnt <= cnt + 1'b1;
  end

  // Scan index: steps one digit per terminal count, wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  idx <= '0;
    else if (tc) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  // Shadow capture at frame boundaries; loads seen mid-frame are remembered as pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blank_lz <= 1'b0;
      pending     <= 1'b0;
    end else if (boundary) begin
      if (pending || bus.load) begin
        sh_digits   <= bus.digits;
        sh_dp       <= bus.dp_in;
        sh_en       <= bus.digit_en;
        sh_blank_lz <= bus.blank_lz;
      end
      pending <= 1'b0;
    end else if (bus.load) begin
      pending <= 1'b1;
    end
  end

  // Next-pin decode for the digit under the scan index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    zero_run = 1'b1;
    lz_blank = '0;
    anode_nx = '1;
    seg_nx   = 7'h7F;
    dp_nx    = 1'b1;
    // A digit is a leading zero when it and every more significant digit are zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run & (sh_digits[4*k +: 4] == 4'h0);
      lz_blank[k] = sh_blank_lz & zero_run & (k != 0);
    end
    cur_nib = sh_digits[int'(idx)*4 +: 4];
    blank   = !sh_en[idx] || lz_blank[idx];
    if (!blank) begin
      anode_nx[idx] = 1'b0;
      seg_nx        = seg_lut(cur_nib);
      dp_nx         = ~sh_dp[idx];
    end
  end

  // Registered pins: lag the index by one cycle, glitch-free at the board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.anode      <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.seg        <= seg_nx;
      bus.dp         <= dp_nx;
      bus.anode      <= anode_nx;
      bus.frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with 4 digits and a 4-cycle dwell.
module tb_seven_seg_scan;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DARK = {4'hF, 7'h7F, 1'b1};

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .CNT_W      (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic disp_t lit(input int k, input logic [6:0] s, input logic d);
    disp_t r;
    r.anode    = 4'hF;
    r.anode[k] = 1'b0;
    r.seg      = s;
    r.dp       = d;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input disp_t e);
    check({tag, "_anode"}, 32'(bus.anode), 32'(e.anode));
    check({tag, "_seg"},   32'(bus.seg),   32'(e.seg));
    check({tag, "_dp"},    32'(bus.dp),    32'(e.dp));
  endtask

  // One clock, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slots(input string tag, input disp_t e, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_disp(tag, e);
    end
  endtask

  // Called on a frame_tick sample; checks the following 16 samples and the next tick.
  task automatic check_frame(input string tag, input disp_t e0, input disp_t e1,
                             input disp_t e2, input disp_t e3);
    check_slots({tag, "_d0"}, e0, 4);
    check_slots({tag, "_d1"}, e1, 4);
    check_slots({tag, "_d2"}, e2, 4);
    check_slots({tag, "_d3"}, e3, 4);
    check({tag, "_tick"}, 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    step();
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_wait_tick"}, 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic apply(input logic [15:0] d, input logic [3:0] p,
                       input logic [3:0] en, input logic blz);
    bus.digits   = d;
    bus.dp_in    = p;
    bus.digit_en = en;
    bus.blank_lz = blz;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.digits   = '0;
    bus.dp_in    = '0;
    bus.digit_en = '0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;
    repeat (3) @(negedge clk);
    check_disp("reset", DARK);
    check("reset_tick", 32'(bus.frame_tick), 32'd0);

    // 1: no load, dark, ticks at samples 15 and 31 after release
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check_disp("noload", DARK);
      check("noload_tick", 32'(bus.frame_tick), 32'((i == 15) || (i == 31)));
    end

    // 2: basic frame
    apply(16'h1A2F, 4'b0100, 4'hF, 1'b0);
    wait_tick("basic");
    check_frame("basic", lit(0, 7'b0001110, 1'b1), lit(1, 7'b0100100, 1'b1),
                lit(2, 7'b0001000, 1'b0), lit(3, 7'b1111001, 1'b1));

    // Per-digit enable masking
    apply(16'hDA2D, 4'b0000, 4'b0101, 1'b0);
    wait_tick("en");
    check_frame("en", lit(0, 7'b0100001, 1'b1), DARK, lit(2, 7'b0001000, 1'b1), DARK);

    // 3: leading-zero suppression
    apply(16'h0040, 4'b0000, 4'hF, 1'b1);
    wait_tick("lz");
    check_frame("lz", lit(0, 7'b1000000, 1'b1), lit(1, 7'b0011001, 1'b1), DARK, DARK);

    // 4: all zero, digit 0 stays lit
    apply(16'h0000, 4'b0000, 4'hF, 1'b1);
    wait_tick("lz0");
    check_frame("lz0", lit(0, 7'b1000000, 1'b1), DARK, DARK, DARK);

    // Remaining glyphs
    apply(16'h9876, 4'b1000, 4'hF, 1'b0);
    wait_tick("lut");
    check_frame("lut", lit(0, 7'b0000010, 1'b1), lit(1, 7'b1111000, 1'b1),
                lit(2, 7'b0000000, 1'b1), lit(3, 7'b0010000, 1'b0));

    // 5a: load mid-frame, old frame completes first
    check_slots("mid_old_d0", lit(0, 7'b0000010, 1'b1), 4);
    check_slots("mid_old_d1", lit(1, 7'b1111000, 1'b1), 2);
    apply(16'h5555, 4'b0000, 4'hF, 1'b0);
    check_slots("mid_old_d1", lit(1, 7'b1111000, 1'b1), 1);
    check_slots("mid_old_d2", lit(2, 7'b0000000, 1'b1), 4);
    check_slots("mid_old_d3", lit(3, 7'b0010000, 1'b0), 4);
    check("mid_tick", 32'(bus.frame_tick), 32'd1);
    check_frame("mid_new", lit(0, 7'b0010010, 1'b1), lit(1, 7'b0010010, 1'b1),
                lit(2, 7'b0010010, 1'b1), lit(3, 7'b0010010, 1'b1));

    // 5b: load on the boundary cycle takes effect at index 0 at once
    check_slots("co_old_d0", lit(0, 7'b0010010, 1'b1), 4);
    check_slots("co_old_d1", lit(1, 7'b0010010, 1'b1), 4);
    check_slots("co_old_d2", lit(2, 7'b0010010, 1'b1), 4);
    check_slots("co_old_d3", lit(3, 7'b0010010, 1'b1), 3);
    apply(16'hC3EB, 4'b0001, 4'hF, 1'b0);
    check("co_tick", 32'(bus.frame_tick), 32'd1);
    check_frame("co_new", lit(0, 7'b0000011, 1'b0), lit(1, 7'b0000110, 1'b1),
                lit(2, 7'b0110000, 1'b1), lit(3, 7'b1000110, 1'b1));

    // 6: asynchronous reset between edges, with a load pending
    check_slots("prerst", lit(0, 7'b0000011, 1'b0), 2);
    apply(16'h5555, 4'b0000, 4'hF, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_disp("async_rst", DARK);
    check("async_rst_tick", 32'(bus.frame_tick), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      step();
      check_disp("postrst", DARK);
    end

    // Recovery after a fresh load
    apply(16'h1A2F, 4'b0100, 4'hF, 1'b0);
    wait_tick("recover");
    check_frame("recover", lit(0, 7'b0001110, 1'b1), lit(1, 7'b0100100, 1'b1),
                lit(2, 7'b0001000, 1'b0), lit(3, 7'b1111001, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised, time-multiplexed seven-segment display driver.
- Accepts NUM_DIGITS packed hex nibbles plus per-digit decimal-point and enable bits, and latches them into shadow registers at frame boundaries so the display never tears mid-frame.
- Scans the digits using an internal refresh prescaler and drives active-low segments and anodes.
- Sits between the datapath (counters, registers under display) and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit is lit; legal range >= 1.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  packed hex values; digit i is digits[4i+3:4i]; digit NUM_DIGITS-1 is the most significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit; 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit forced dark.
- blank_lz  in  1  leading-zero suppression enable.
- load  in  1  single-cycle strobe requesting a capture of digits, dp_in, digit_en and blank_lz.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- anode  out  NUM_DIGITS  digit selects, active-low, at most one low, registered.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).

Reset values:
- prescaler = 0 and scan index = 0.
- Shadow digits = 0, shadow dp = 0, shadow enables = 0, shadow blank_lz = 0; pending-load flag = 0.
- Outputs: seg = 7'h7F, dp = 1, anode = all 1s, frame_tick = 0.
- The display stays dark until the first load is applied.
- Reset asserted mid-operation immediately forces all of the above, regardless of clk.

Prescaler:
- Counts 0..REFRESH_DIV-1, then wraps to 0.
- tc (terminal count) is high when prescaler == REFRESH_DIV-1.
- REFRESH_DIV = 1 makes tc high every cycle.

Scan index:
- On tc, the index advances by one; NUM_DIGITS-1 wraps to 0.
- NUM_DIGITS = 1: the index stays at 0.

Frame boundary:
- Defined as tc high with index == NUM_DIGITS-1.
- At a frame boundary, if the pending flag or load is high:
  - copy the inputs into the shadow registers;
  - clear the pending flag.
- load outside a boundary sets the pending flag; repeated loads before the boundary collapse into one.
- The inputs are sampled at the boundary cycle itself, not at the load cycle.
- load coincident with a boundary is applied at that boundary.
- frame_tick is registered from the frame boundary, so it is high for the one cycle in which index = 0 first appears.

Decode (combinational from index and shadow, then registered; outputs lag the index by exactly 1 cycle):
- Segment encodings, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Digit k is blank if either:
  - shadow enable[k] = 0; or
  - shadow blank_lz = 1, k != 0, and digit k and every higher digit equal 0.
- Digit 0 is never blanked by leading-zero suppression.
- Blank digit: anode all 1s, seg = 7'h7F, dp = 1.
- Lit digit: anode[index] = 0 and the others 1; seg = decode; dp = ~shadow dp[index].

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS = 4, REFRESH_DIV = 4.
1. Reset then no load, run 40 cycles -> anode = 4'b1111, seg = 7'h7F, dp = 1 throughout; frame_tick pulses every 16 cycles.
2. load with digits = 16'h1A2F, digit_en = 4'hF, dp_in = 4'b0100, blank_lz = 0 -> from the next frame, 4 cycles each:
   - anode 1110/seg 0001110
   - anode 1101/seg 0100100
   - anode 1011/seg 0001000/dp 0
   - anode 0111/seg 1111001
3. blank_lz = 1, digits = 16'h0040 -> digits 3 and 2 dark; digit 1 shows 0011001; digit 0 shows 1000000.
4. blank_lz = 1, digits = 16'h0000 -> only digit 0 lit, showing 1000000.
5. load mid-frame with new digits = 16'h5555 -> remainder of the frame shows the old values; 0010010 appears on all digits only after the next frame_tick. Also: load coincident with a boundary -> new values show at index 0 immediately.
6. Assert rst_n low for 3 ns between clk edges mid-scan -> outputs go to their reset values asynchronously; after release the display is dark until a new load is applied.
